// File: rtl/prefix_adder_seq_pkg.sv
// Shared definitions for the multi-cycle prefix adder/subtractor:
// operation encoding, FSM state encoding, default sizes and a clog2 helper.
package prefix_adder_seq_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 256;
  localparam int DEF_CHUNK = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Ceiling log2, used for counter and tree-depth sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int x = value - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_adder_seq_if.sv
// Request/result bus of prefix_adder_seq.
// Optional macro PREFIX_ADDER_SEQ_ZERO_EN adds the 'zero' result flag.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both 1; a result transfers on an edge where out_valid and
// out_ready are both 1. A producer never waits on the consumer's ready
// before raising valid, and keeps its payload stable while valid is held.
interface prefix_adder_seq_if
  import prefix_adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
  logic             zero;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy, zero
  );
  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy, zero
  );
`else
  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/prefix_adder_seq_chunk.sv
// prefix_adder_chunk: combinational CHUNK-bit adder slice built on a
// parallel-prefix (g,p) tree. Returns the CHUNK sum bits and the carry
// leaving the chunk for a given carry-in.
module prefix_adder_chunk
  import prefix_adder_seq_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);
  localparam int LEVELS = clog2(CHUNK);

  // Per-bit generate/propagate pairs.
  logic [CHUNK-1:0] g0;
  logic [CHUNK-1:0] p0;
  assign g0 = a_i & b_i;
  assign p0 = a_i ^ b_i;

  // Kogge-Stone levels: after level l, bit i holds G/P over [i : i-2^(l+1)+1].
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int D = 1 << l;
    logic [CHUNK-1:0] g_in;
    logic [CHUNK-1:0] p_in;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    if (l == 0) begin : g_first
      assign g_in = g0;
      assign p_in = p0;
    end else begin : g_next
      assign g_in = g_lvl[l-1].g;
      assign p_in = g_lvl[l-1].p;
    end
    // Low D bits have no partner at this distance and pass through.
    assign g = g_in | (p_in & (g_in << D));
    assign p = p_in & ~((~p_in) << D);
  end

  // Prefix G[i:0]/P[i:0]; the top pair is the group (G,P) of the chunk.
  logic [CHUNK-1:0] gpre;
  logic [CHUNK-1:0] ppre;
  assign gpre = g_lvl[LEVELS-1].g;
  assign ppre = g_lvl[LEVELS-1].p;

  // Carry into bit i is the prefix over bits below it combined with c_i.
  logic [CHUNK-1:0] carry;
  assign carry = {gpre[CHUNK-2:0] | (ppre[CHUNK-2:0] & {(CHUNK-1){c_i}}), c_i};
  assign s_o   = p0 ^ carry;
  assign c_o   = gpre[CHUNK-1] | (ppre[CHUNK-1] & c_i);

endmodule

// File: rtl/prefix_adder_seq.sv
// prefix_adder_seq: WIDTH-bit add/sub computed one CHUNK per cycle, LSB
// chunk first, through a single prefix_adder_chunk and a carry register.
// Optional macro PREFIX_ADDER_SEQ_ZERO_EN adds a per-chunk accumulated
// result==0 flag.
module prefix_adder_seq
  import prefix_adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                clk,
  input  logic                reset,
  prefix_adder_seq_if.slave   bus,
  output state_t              state_o
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
  logic             zero_acc_q, zero_acc_d;
`endif

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;

  prefix_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i (a_q[int'(cnt_q)*CHUNK +: CHUNK]),
    .b_i (b_q[int'(cnt_q)*CHUNK +: CHUNK]),
    .c_i (carry_q),
    .s_o (chunk_sum),
    .c_o (chunk_cout)
  );

  // Next-state: capture in IDLE, one chunk per RUN cycle, hold in DONE.
  // out_valid rises one cycle after entering DONE so the result is
  // presented from settled registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
    zero_acc_d  = zero_acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
          carry_d = bus.op_sub;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
          zero_acc_d = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        sum_d[int'(cnt_q)*CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
        zero_acc_d = zero_acc_q & ~(|chunk_sum);
`endif
        if (cnt_q == LAST) begin
          cout_d  = chunk_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
      zero_acc_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
      zero_acc_q  <= zero_acc_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
  assign bus.zero      = zero_acc_q & out_valid_q;
`endif
  assign state_o       = state_q;

endmodule

// File: tb/tb_prefix_adder_seq.sv
// Self-checking bench for prefix_adder_seq (WIDTH=256, CHUNK=32).
// Honours PREFIX_ADDER_SEQ_ZERO_EN when defined.
module tb_prefix_adder_seq;
  import prefix_adder_seq_pkg::*;

  localparam int W   = 256;
  localparam int C   = 32;
  localparam int LAT = W / C + 1;
  localparam int NV  = 14;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  prefix_adder_seq_if #(.WIDTH(W)) bus ();

  prefix_adder_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_c_q[$];
  vec_t         tbl[NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference arithmetic: {cout, sum} of a + b or a - b (as a + ~b + 1).
  function automatic logic [W:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bb;
    bb = op ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op};
  endfunction

  // Driver: present a request while idle, push its expectation on accept.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    check1("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    exp_q.push_back(es);
    exp_c_q.push_back(ec);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid, scrambling a/b meanwhile; check latency, busy span, result.
  task automatic wait_result();
    int           n;
    int           busy_n;
    logic [W-1:0] es;
    logic         ec;
    n      = 0;
    busy_n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      if (bus.busy === 1'b1) busy_n++;
      bus.a      = {8{$urandom()}};
      bus.b      = {8{$urandom()}};
      bus.op_sub = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", W'(n), W'(LAT));
    check("busy_cycles", W'(busy_n), W'(LAT - 1));
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", W'(1), W'(0));
    end else begin
      es = exp_q.pop_front();
      ec = exp_c_q.pop_front();
      check("sum", bus.sum, es);
      check1("cout", bus.cout, ec);
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
      check1("zero", bus.zero, (es == '0));
`endif
    end
  endtask

  // Hold out_ready low for 'cycles' edges; result must stay put.
  task automatic hold_check(input int cycles);
    logic [W-1:0] s0;
    logic         c0;
    logic         ok;
    s0 = bus.sum;
    c0 = bus.cout;
    ok = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.sum !== s0 || bus.cout !== c0 || bus.in_ready !== 1'b0)
        ok = 1'b0;
    end
    check1("backpressure_hold", ok, 1'b1);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check1("out_valid_after_hs", bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [W:0] m;
    logic       seen;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;

    // Directed vectors with hand-derived results.
    tbl[0] = '{OP_ADD, W'(1), {W{1'b1}}, '0, 1'b1};
    tbl[1] = '{OP_SUB, W'(5), W'(7), {{(W-1){1'b1}}, 1'b0}, 1'b0};
    tbl[2] = '{OP_ADD, W'(64'hFFFF_FFFF), W'(1), W'(64'h1_0000_0000), 1'b0};
    tbl[3] = '{OP_ADD, (W'(1) << 224) - W'(1), W'(1), W'(1) << 224, 1'b0};
    tbl[4] = '{OP_SUB, W'(7), W'(7), '0, 1'b1};
    tbl[5] = '{OP_ADD, W'(1), W'(0), W'(1), 1'b0};
    tbl[6] = '{OP_ADD, {W{1'b1}}, {W{1'b1}}, {{(W-1){1'b1}}, 1'b0}, 1'b1};
    tbl[7] = '{OP_SUB, W'(0), W'(1), {W{1'b1}}, 1'b0};
    // Random vectors checked against the arithmetic model.
    for (int i = 8; i < NV; i++) begin
      tbl[i].op = 1'($urandom_range(0, 1));
      tbl[i].a  = {8{$urandom()}};
      tbl[i].b  = {8{$urandom()}};
      m = model(tbl[i].op, tbl[i].a, tbl[i].b);
      tbl[i].exp_sum  = m[W-1:0];
      tbl[i].exp_cout = m[W];
    end

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check("rst_sum", bus.sum, '0);
    check1("rst_cout", bus.cout, 1'b0);
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
`ifdef PREFIX_ADDER_SEQ_ZERO_EN
    check1("rst_zero", bus.zero, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Table pass.
    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_sum, tbl[i].exp_cout);
      wait_result();
      hold_check($urandom_range(1, 3));
      handshake();
    end

    // Backpressure with a second request held valid during DONE.
    issue(OP_ADD, W'(10), W'(20), W'(30), 1'b0);
    wait_result();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_sub   = OP_ADD;
    bus.a        = W'(3);
    bus.b        = W'(4);
    hold_check(5);
    handshake();
    check1("no_accept_on_hs_busy", bus.busy, 1'b0);
    check1("in_ready_after_hs", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    check1("accept_after_hs", bus.busy, 1'b1);
    exp_q.push_back(W'(7));
    exp_c_q.push_back(1'b0);
    bus.in_valid = 1'b0;
    wait_result();
    handshake();

    // Reset during the third RUN cycle discards the operation.
    issue(OP_ADD, W'(1) << 200, W'(5), (W'(1) << 200) + W'(5), 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check1("busy_before_mid_reset", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check1("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_sum", bus.sum, '0);
    check1("mid_rst_cout", bus.cout, 1'b0);
    check1("mid_rst_busy", bus.busy, 1'b0);
    check1("mid_rst_in_ready", bus.in_ready, 1'b1);
    void'(exp_q.pop_back());
    void'(exp_c_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    check1("no_result_after_reset", seen, 1'b0);
    issue(OP_ADD, W'(3), W'(4), W'(7), 1'b0);
    wait_result();
    handshake();

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
